fetch_stage: RTL

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage_pkg.sv | 25 ++
 rtl/fetch_stage_if_id_reg.sv | 59 +++++
 rtl/fetch_stage.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/fetch_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_stage_pkg
//  Description : Shared pipeline constants for the fetch stage: state
//                encoding, bubble instruction word and default reset PC.
//  Revision    : 1.0  initial release
// ============================================================================
package fetch_stage_pkg;

    localparam logic [31:0] C_NOP_INST = 32'h0000_0000;
    localparam logic [31:0] C_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,   // request outstanding, data delivered on ready
        ST_DRAIN = 2'd1,   // request outstanding, returning data thrown away
        ST_HOLD  = 2'd2    // no request, fetched word parked in skid register
    } fetch_state_t;

    // Redirect targets always land on a word boundary.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_stage_if_id_reg.sv
`default_nettype none
// ============================================================================
//  Module      : if_id_reg
//  Description : IF/ID pipeline register with hold, load and bubble controls.
//                Priority: rst > hold > load > bubble. A bubble replaces the
//                instruction with NOP_INST and clears valid; the PC fields
//                keep their previous value.
//  Revision    : 1.0  initial release
// ============================================================================
module if_id_reg
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] NOP_INST = C_NOP_INST
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_hold,
    input  logic        i_load,
    input  logic        i_bubble,
    input  logic [31:0] i_inst,
    input  logic [31:0] i_pc,
    output logic [31:0] o_inst,
    output logic [31:0] o_pc,
    output logic [31:0] o_pc4,
    output logic        o_valid
);

    logic [31:0] r_inst;
    logic [31:0] r_pc;
    logic [31:0] r_pc4;
    logic        r_valid;

    // Pipeline register update: hold wins over load, load over bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_inst  <= NOP_INST;
            r_pc    <= 32'h0;
            r_pc4   <= 32'h0;
            r_valid <= 1'b0;
        end else if (i_hold) begin
            r_inst  <= r_inst;
        end else if (i_load) begin
            r_inst  <= i_inst;
            r_pc    <= i_pc;
            r_pc4   <= i_pc + 32'd4;
            r_valid <= 1'b1;
        end else if (i_bubble) begin
            r_inst  <= NOP_INST;
            r_valid <= 1'b0;
        end
    end

    assign o_inst  = r_inst;
    assign o_pc    = r_pc;
    assign o_pc4   = r_pc4;
    assign o_valid = r_valid;

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_stage
//  Description : Instruction fetch stage with stall skid buffer and redirect
//                draining of an in-flight imem request.
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = C_RESET_PC,
    parameter logic [31:0] NOP_INST = C_NOP_INST
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        isbranch,
    input  logic [31:0] branch_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc4,
    output logic        id_valid
);

    fetch_state_t r_state, w_state_nxt;
    logic [31:0]  r_pc,   w_pc_nxt;
    logic [31:0]  r_skid, w_skid_nxt;
    logic [31:0]  r_pend, w_pend_nxt;
    logic [31:0]  w_target;
    logic [31:0]  w_pc4;
    logic         w_hold, w_load, w_bubble;
    logic [31:0]  w_load_inst;

    assign w_target = align_word(branch_pc);
    assign w_pc4    = r_pc + 32'd4;

    // No request while in reset or while a word is parked; address is the PC,
    // which only moves when the outstanding request has completed.
    assign imem_req  = ~rst & (r_state != ST_HOLD);
    assign imem_addr = r_pc;

    // State, PC, skid and pending-target registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_FETCH;
            r_pc    <= RESET_PC;
            r_skid  <= 32'h0;
            r_pend  <= 32'h0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_skid  <= w_skid_nxt;
            r_pend  <= w_pend_nxt;
        end
    end

    // Next-state and IF/ID control; stall overrides any redirect request.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_skid_nxt  = r_skid;
        w_pend_nxt  = r_pend;
        w_hold      = 1'b0;
        w_load      = 1'b0;
        w_bubble    = 1'b0;
        w_load_inst = imem_rdata;
        if (stall) begin
            w_hold = 1'b1;
            if ((r_state == ST_FETCH) && imem_ready) begin
                w_skid_nxt  = imem_rdata;
                w_state_nxt = ST_HOLD;
            end
        end else begin
            case (r_state)
                ST_FETCH: begin
                    if (isbranch) begin
                        w_bubble = 1'b1;
                        if (imem_ready) begin
                            w_pc_nxt = w_target;
                        end else begin
                            w_pend_nxt  = w_target;
                            w_state_nxt = ST_DRAIN;
                        end
                    end else if (imem_ready) begin
                        w_load   = 1'b1;
                        w_pc_nxt = w_pc4;
                    end else begin
                        w_bubble = 1'b1;
                    end
                end
                ST_DRAIN: begin
                    w_bubble = 1'b1;
                    if (isbranch) begin
                        w_pend_nxt = w_target;
                    end
                    if (imem_ready) begin
                        w_pc_nxt    = isbranch ? w_target : r_pend;
                        w_state_nxt = ST_FETCH;
                    end
                end
                ST_HOLD: begin
                    w_state_nxt = ST_FETCH;
                    if (isbranch) begin
                        w_bubble = 1'b1;
                        w_pc_nxt = w_target;
                    end else begin
                        w_load      = 1'b1;
                        w_load_inst = r_skid;
                        w_pc_nxt    = w_pc4;
                    end
                end
                default: begin
                    w_bubble    = 1'b1;
                    w_state_nxt = ST_FETCH;
                end
            endcase
        end
    end

    if_id_reg #(
        .NOP_INST (NOP_INST)
    ) u_if_id_reg (
        .clk      (clk),
        .rst      (rst),
        .i_hold   (w_hold),
        .i_load   (w_load),
        .i_bubble (w_bubble),
        .i_inst   (w_load_inst),
        .i_pc     (r_pc),
        .o_inst   (id_inst),
        .o_pc     (id_pc),
        .o_pc4    (id_pc4),
        .o_valid  (id_valid)
    );

endmodule
`default_nettype wire
